// File: rtl/zxuno_audio_pkg.sv
// Shared constants and types for the parametrised ZX-Uno audio mixer.
package zxuno_audio_pkg;

  localparam int unsigned SAMPLE_W = 12;
  localparam int unsigned VOL_W    = 4;
  localparam int unsigned PCM_W    = 8;
  localparam int unsigned SAT_MAX  = (1 << SAMPLE_W) - 1;

  // Register map: channel volumes start at OFS_VOL0, master sits just past the last channel
  localparam int unsigned OFS_VOL0 = 0;

  // Master control register layout
  localparam int unsigned MB_MUTE  = 0;
  localparam int unsigned MB_BEEP  = 1;
  localparam int unsigned MB_EAR   = 2;
  localparam int unsigned MASTER_W = 3;
  localparam logic [MASTER_W-1:0] MASTER_RESET = 3'b110;

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StSat
  } mix_state_e;

  // Master register offset for a mixer with nch PCM channels
  function automatic int unsigned ofs_master(input int unsigned nch);
    return OFS_VOL0 + nch;
  endfunction

endpackage

// File: rtl/sigma_delta_dac.sv
// First-order sigma-delta modulator: the carry of a running sum is the output bit.
module sigma_delta_dac #(
  parameter int unsigned W = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] sample,
  output logic         dout
);

  logic [W-1:0] r_acc;
  logic         r_out;
  logic [W:0]   w_sum;

  assign w_sum = {1'b0, r_acc} + {1'b0, sample};
  assign dout  = r_out;

  // Accumulate every clock; the carry density equals sample / 2^W
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_out <= 1'b0;
    end else begin
      r_acc <= w_sum[W-1:0];
      r_out <= w_sum[W];
    end
  end

endmodule

// File: rtl/zxuno_audio_mixer_n.sv
// N-channel PCM + beeper mixer with per-channel volume, saturation and 1-bit DAC output.
module zxuno_audio_mixer_n
  import zxuno_audio_pkg::*;
#(
  parameter int unsigned        NCH        = 4,
  parameter logic [7:0]         REG_BASE   = 8'hF0,
  parameter int unsigned        SAMPLE_DIV = 256,
  parameter logic [VOL_W-1:0]   VOL_RESET  = 4'd8,
  parameter logic [SAMPLE_W-1:0] SPK_LVL   = 12'd1023,
  parameter logic [SAMPLE_W-1:0] EAR_LVL   = 12'd512,
  parameter logic [SAMPLE_W-1:0] MIC_LVL   = 12'd256
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             zxuno_addr,
  input  logic                   zxuno_regrd,
  input  logic                   zxuno_regwr,
  input  logic [7:0]             din,
  output logic [7:0]             dout,
  output logic                   oe_n,
  input  logic [NCH*PCM_W-1:0]   pcm_in,
  input  logic                   spk,
  input  logic                   mic,
  input  logic                   ear,
  output logic [SAMPLE_W-1:0]    sample_out,
  output logic                   sample_valid,
  output logic                   audio_out
);

  localparam int unsigned ACC_W      = SAMPLE_W + $clog2(NCH + 2);
  localparam int unsigned PROD_W     = PCM_W + VOL_W;
  localparam int unsigned CH_W       = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned DIV_W      = $clog2(SAMPLE_DIV);
  localparam int unsigned OFS_MASTER = ofs_master(NCH);

  // Register file
  logic [VOL_W-1:0]    r_vol [NCH];
  logic [MASTER_W-1:0] r_master;

  // Sweep datapath
  mix_state_e          r_state, w_state_d;
  logic [PCM_W-1:0]    r_pcm_sh [NCH];
  logic [VOL_W-1:0]    r_vol_sh [NCH];
  logic                r_mute_sh;
  logic [ACC_W-1:0]    r_acc;
  logic [CH_W-1:0]     r_ch;
  logic [SAMPLE_W-1:0] r_sample;
  logic                r_valid;
  logic [DIV_W-1:0]    r_div;
  logic                r_ear_meta, r_ear_sync;

  logic [8:0]          w_ofs;
  logic                w_in_range;
  logic                w_tick;
  logic [ACC_W-1:0]    w_beep;
  logic [PCM_W-1:0]    w_pcm_sel;
  logic [VOL_W-1:0]    w_vol_sel;
  logic [PROD_W-1:0]   w_prod;
  logic [SAMPLE_W-1:0] w_sat;
  logic                w_unused_din;

  // 9-bit offset so addresses below REG_BASE land far out of range instead of wrapping
  assign w_ofs        = {1'b0, zxuno_addr} - {1'b0, REG_BASE} - 9'(OFS_VOL0);
  assign w_in_range   = (w_ofs <= 9'(OFS_MASTER));
  assign w_tick       = (r_div == DIV_W'(SAMPLE_DIV - 1));
  assign w_prod       = PROD_W'(w_pcm_sel) * PROD_W'(w_vol_sel);
  assign w_sat        = (r_acc > ACC_W'(SAT_MAX)) ? SAMPLE_W'(SAT_MAX) : r_acc[SAMPLE_W-1:0];
  assign w_unused_din = ^din[7:VOL_W];

  assign sample_out   = r_sample;
  assign sample_valid = r_valid;

  // CPU writes to volume and master registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NCH; k++) r_vol[k] <= VOL_RESET;
      r_master <= MASTER_RESET;
    end else if (zxuno_regwr && w_in_range) begin
      if (w_ofs == 9'(OFS_MASTER)) r_master <= din[MASTER_W-1:0];
      for (int k = 0; k < NCH; k++) begin
        if (w_ofs == 9'(k)) r_vol[k] <= din[VOL_W-1:0];
      end
    end
  end

  // Combinational readback; a same-cycle write is only visible after the edge
  always_comb begin
    dout = '0;
    oe_n = 1'b1;
    if (zxuno_regrd && w_in_range) begin
      oe_n = 1'b0;
      if (w_ofs == 9'(OFS_MASTER)) dout = 8'(r_master);
      for (int k = 0; k < NCH; k++) begin
        if (w_ofs == 9'(k)) dout = 8'(r_vol[k]);
      end
    end
  end

  // Two-flop synchroniser for the asynchronous tape input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ear_meta <= 1'b0;
      r_ear_sync <= 1'b0;
    end else begin
      r_ear_meta <= ear;
      r_ear_sync <= r_ear_meta;
    end
  end

  // Sample-rate divider
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_div <= '0;
    else        r_div <= w_tick ? '0 : r_div + DIV_W'(1);
  end

  // Beeper/ear starting value for the accumulator, gated by live master bits at the tick
  always_comb begin
    w_beep = '0;
    if (r_master[MB_BEEP]) begin
      if (spk) w_beep = w_beep + ACC_W'(SPK_LVL);
      if (mic) w_beep = w_beep + ACC_W'(MIC_LVL);
    end
    if (r_master[MB_EAR] && r_ear_sync) w_beep = w_beep + ACC_W'(EAR_LVL);
  end

  // Select the shadowed channel being accumulated this cycle
  always_comb begin
    w_pcm_sel = '0;
    w_vol_sel = '0;
    for (int k = 0; k < NCH; k++) begin
      if (r_ch == CH_W'(k)) begin
        w_pcm_sel = r_pcm_sh[k];
        w_vol_sel = r_vol_sh[k];
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= StIdle;
    else        r_state <= w_state_d;
  end

  // FSM next state: one ACCUM cycle per channel, then one SAT cycle
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (w_tick) w_state_d = StAccum;
      StAccum: if (r_ch == CH_W'(NCH - 1)) w_state_d = StSat;
      StSat:   w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  // Sweep datapath: snapshot on tick, multiply-accumulate, then saturate and publish
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NCH; k++) begin
        r_pcm_sh[k] <= '0;
        r_vol_sh[k] <= '0;
      end
      r_mute_sh <= 1'b0;
      r_acc     <= '0;
      r_ch      <= '0;
      r_sample  <= '0;
      r_valid   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        StIdle: begin
          if (w_tick) begin
            for (int k = 0; k < NCH; k++) begin
              r_pcm_sh[k] <= pcm_in[k*PCM_W +: PCM_W];
              r_vol_sh[k] <= r_vol[k];
            end
            r_mute_sh <= r_master[MB_MUTE];
            r_acc     <= w_beep;
            r_ch      <= '0;
          end
        end
        StAccum: begin
          r_acc <= r_acc + ACC_W'(w_prod);
          r_ch  <= r_ch + CH_W'(1);
        end
        StSat: begin
          r_sample <= r_mute_sh ? '0 : w_sat;
          r_valid  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  sigma_delta_dac #(
    .W(SAMPLE_W)
  ) u_dac (
    .clk   (clk),
    .rst_n (rst_n),
    .sample(r_sample),
    .dout  (audio_out)
  );

endmodule

// File: doc/zxuno_audio_mixer_n.md
Name: zxuno_audio_mixer_n

Overview:
- Parametrised successor to the fixed two-AY audio mixer.
- Mixes NCH 8-bit PCM sources (AY channels, future DAC/covox sources) plus the spk/mic/ear beeper bits.
- Each PCM channel has a 4-bit volume, programmable through the ZX-Uno register port.
- Produces a saturated 12-bit sample and a first-order sigma-delta 1-bit audio output. Sits beside the turbosound and ULA at top level and replaces the old mixer instance.

Parameters:
- NCH, 4, number of PCM channels (1..16)
- REG_BASE, 8'hF0, ZX-Uno register address of channel 0 volume; channel k is at REG_BASE+k, master control at REG_BASE+NCH
- SAMPLE_DIV, 256, clocks per sample tick; must be >= NCH+3
- VOL_RESET, 4'd8, reset volume for every channel
- SPK_LVL, 12'd1023, beeper contribution when spk=1
- EAR_LVL, 12'd512, ear monitor contribution
- MIC_LVL, 12'd256, mic contribution

Ports:
- clk  in  1  system clock (28 MHz)
- rst_n  in  1  asynchronous active-low reset
- zxuno_addr  in  8  current ZX-Uno register address
- zxuno_regrd  in  1  read strobe on the ZX-Uno data port
- zxuno_regwr  in  1  write strobe on the ZX-Uno data port
- din  in  8  CPU write data
- dout  out  8  register read data
- oe_n  out  1  low when dout is valid for the CPU bus mux
- pcm_in  in  NCH*8  channel k is bits [8k+7:8k], unsigned
- spk  in  1  ULA speaker bit
- mic  in  1  ULA mic bit
- ear  in  1  tape input, asynchronous
- sample_out  out  12  latched mixed sample
- sample_valid  out  1  one-clock pulse when sample_out updates
- audio_out  out  1  sigma-delta bitstream

Behaviour:
- Reset (asynchronous, rst_n=0): all volumes = VOL_RESET; master = 8'h06; sample_out=0; sample_valid=0; audio_out=0; DAC accumulator=0; divider=0; FSM=IDLE; dout=0; oe_n=1.
- Master register bits:
  - bit0: mute
  - bit1: beeper enable (spk/mic)
  - bit2: ear monitor enable
  - bits7:3 read as 0; writes to them are ignored.
- Register access:
  - Write: zxuno_regwr=1 with zxuno_addr in [REG_BASE, REG_BASE+NCH] writes din on that clock edge; volume takes din[3:0].
  - Read: combinational. oe_n=0 iff zxuno_regrd=1 and address in range. dout = {4'b0,vol} or master; dout=0 when oe_n=1.
  - Read and write in the same cycle: read returns the old value.
- ear: passes through a 2-FF synchroniser before use.
- Divider: counts 0..SAMPLE_DIV-1 and wraps. Tick when count == SAMPLE_DIV-1.
- FSM states:
  - IDLE: on tick, snapshot all pcm_in and all volumes into shadow registers, load acc = beeper terms, ch=0, go to ACCUM.
    - Beeper terms: SPK_LVL*spk + MIC_LVL*mic when bit1 is set; plus EAR_LVL*ear_sync when bit2 is set.
  - ACCUM: acc += pcm_shadow[ch]*vol_shadow[ch]. Product width is 12 bits; acc width is 12+clog2(NCH+2). ch++. After ch=NCH-1, go to SAT.
  - SAT: sample_out = mute ? 0 : min(acc,4095); sample_valid=1 for this cycle only; go to IDLE.
  - Latency: tick → sample_valid is NCH+2 clocks.
- Register writes during a sweep do not affect that sweep; they apply from the next tick.
- DAC: runs every clock on sample_out. {c,a} = a + sample_out, 13-bit sum; audio_out = c, registered. For a constant sample S, the ones-count over 4096 clocks is exactly S.
- rst_n asserted mid-sweep aborts the sweep; outputs return to reset values immediately.

Decomposition:
- Shared package zxuno_audio_pkg holds:
  - register offsets (OFS_MASTER)
  - master bit indices (MB_MUTE, MB_BEEP, MB_EAR)
  - SAMPLE_W=12, VOL_W=4, PCM_W=8
  - FSM state encoding (IDLE, ACCUM, SAT)
- One sub-module, sigma_delta_dac: parameter W=12; ports clk, rst_n, sample[W-1:0], dout.

Test Plan:
- Reset, then read REG_BASE+0..3 and REG_BASE+4 (NCH=4) → 8'h08 ×4, then 8'h06; oe_n=0 only while zxuno_regrd=1; out-of-range addr 8'hEF → oe_n=1.
- ch0 pcm=8'hFF, vol0 written 8'hAF, other channels pcm=0, spk=mic=0 → sample_out=3825; sample_valid pulses exactly NCH+2=6 clocks after the tick; ch0 readback = 8'h0F.
- All four channels pcm=8'hFF, vol=15, spk=1 → raw 16323 → sample_out=4095 (saturation).
- Write master 8'h01 (mute) with nonzero mix → next sample_out=0; audio_out stays 0 after the next full 4096-clock window.
- Hold sample_out=2048 → exactly 2048 ones in any aligned 4096-clock window of audio_out. Hold 0 → all zeros.
- Write vol0 during ACCUM → the current sample uses the old volume, the next sample uses the new one. Assert rst_n mid-ACCUM → sample_valid never fires, sample_out=0, volumes=8.
